branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
Sequences the ID-stage branch/jump-register resolution path of the 5-stage MIPS pipeline. It detects when a branch operand is produced by an instruction that cannot yet be forwarded (ALU result still in EX, load in EX or MEM). It then stalls IF/ID for the exact number of cycles needed, inserts bubbles into ID/EX, and flushes IF/ID on a taken branch. It sits beside the branch-forwarding mux select logic, which it guarantees sees a forwardable producer when the branch resolves, and it keeps stall/branch statistics.

Parameters:
CNT_W, 16, width of saturating statistics counters

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
Hold  in  1  global freeze (e.g. memory busy); FSM and counters hold while 1
Branch_ID  in  1  ID instruction is a conditional branch (uses rs, rt)
JumpReg_ID  in  1  ID instruction is jr/jalr (uses rs only)
rs  in  5  ID source register A
rt  in  5  ID source register B
BrTaken_ID  in  1  ID comparator result (valid only in resolve cycle)
Rw_EX  in  5  EX destination register
RegWrite_EX  in  1  EX writes register file
MemRead_EX  in  1  EX instruction is a load
Rw_MEM  in  5  MEM destination register
MemRead_MEM  in  1  MEM instruction is a load (RegWrite implied)
Stall_IF_ID  out  1  hold PC and IF/ID register
Bubble_ID_EX  out  1  load NOP into ID/EX
Flush_IF_ID  out  1  squash IF/ID (taken branch / jr)
BrResolve  out  1  ID branch resolves this cycle
StallCnt  out  CNT_W  saturating count of branch stall cycles
BrCnt  out  CNT_W  saturating count of resolved branches/jr
TakenCnt  out  CNT_W  saturating count of taken branches/jr

Behaviour:
- isBr = Branch_ID | JumpReg_ID. matchX(r) = (r == Rw_X) & (r != 0); rt is considered only when Branch_ID.
- Required stalls n (combinational, from current inputs), maximum over the used operands:
  - matchEX & RegWrite_EX & MemRead_EX -> 2.
  - matchEX & RegWrite_EX & !MemRead_EX -> 1.
  - matchMEM & MemRead_MEM -> 1.
  - otherwise 0.
- FSM states: IDLE, STALL. Reset: state=IDLE, cnt=0, all counters 0.
- IDLE, isBr, n==0:
  - BrResolve=1.
  - Flush_IF_ID = JumpReg_ID | BrTaken_ID.
  - BrCnt++; TakenCnt++ if flushing.
- IDLE, isBr, n>0:
  - Stall_IF_ID=1, Bubble_ID_EX=1, StallCnt++.
  - cnt <= n-1; go to STALL if n==2; stay IDLE if n==1 (re-evaluate next cycle, which yields n==0).
- STALL:
  - Stall_IF_ID=1, Bubble_ID_EX=1, StallCnt++.
  - cnt==0 -> IDLE.
  - Recomputed n is ignored in STALL.
- Hold=1:
  - All outputs 0 except counters, which hold.
  - State and cnt frozen.
  - Hold has priority over every transition.
- Non-branch in ID: all control outputs 0, no state change.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-stall: immediate return to IDLE, outputs 0; the ID branch is re-evaluated from scratch after reset release.
- All control outputs are combinational from state and inputs, with zero-cycle latency; only state, cnt and counters are registered.

Decomposition:
- Shared package: stall-class constants (STALL_NONE=0, STALL_ONE=1, STALL_TWO=2), FSM state encoding, zero-register constant (5'd0).
- One sub-module: hazard_depth_calc (combinational n computation), reused by the data-hazard unit for load-use detection.

Test Plan:
- beq rs=5 with lw $5 in EX -> cycle0 Stall/Bubble=1, cycle1 Stall/Bubble=1, cycle2 BrResolve=1; StallCnt=2, BrCnt=1.
- beq rt=7 with add $7 in EX, BrTaken_ID=1 at resolve -> 1 stall cycle, then BrResolve=1 and Flush_IF_ID=1; TakenCnt=1.
- jr rs=0 with add $0 in EX -> no stall; BrResolve=1, Flush_IF_ID=1 in the same cycle.
- bne rs=3 with lw $3 in EX, Hold=1 during the first stall cycle -> outputs 0 and cnt frozen while held; after Hold drops, exactly two stall cycles, then resolve; StallCnt=2.
- Reset pulled low during STALL, released with beq still in ID and no producers -> first cycle after release: BrResolve=1, StallCnt=0.
- With CNT_W=2, five stalled branches -> StallCnt saturates at 3 and never wraps.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants for the ID-stage branch hazard controller and the hazard depth
// calculator: stall classes, FSM encoding and the hard-wired zero register.
package branch_hazard_ctrl_pkg;

  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_ONE  = 2'd1;
  localparam logic [1:0] STALL_TWO  = 2'd2;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_depth_calc.sv
// Number of stall cycles needed before the ID-stage operands can be forwarded,
// taken as the worst case over the operands the ID instruction actually reads.
module hazard_depth_calc
  import branch_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       use_rt,
  input  logic [4:0] Rw_EX,
  input  logic       RegWrite_EX,
  input  logic       MemRead_EX,
  input  logic [4:0] Rw_MEM,
  input  logic       MemRead_MEM,
  output logic [1:0] depth
);

  logic [1:0] depth_rs;
  logic [1:0] depth_rt;

  // A load in EX needs two cycles to reach a forwardable point; an ALU result in
  // EX or a load in MEM needs one.
  function automatic logic [1:0] op_depth(input logic [4:0] r);
    logic ex_hit;
    logic mem_hit;
    ex_hit  = (r == Rw_EX) && (r != ZERO_REG) && RegWrite_EX;
    mem_hit = (r == Rw_MEM) && (r != ZERO_REG) && MemRead_MEM;
    if (ex_hit && MemRead_EX) return STALL_TWO;
    if (ex_hit || mem_hit)    return STALL_ONE;
    return STALL_NONE;
  endfunction

  always_comb begin
    depth_rs = op_depth(rs);
    depth_rt = use_rt ? op_depth(rt) : STALL_NONE;
    depth    = (depth_rs > depth_rt) ? depth_rs : depth_rt;
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jr resolution sequencer: stalls until branch operands are
// forwardable, flushes IF/ID on taken branches and keeps saturating statistics.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Hold,
  input  logic             Branch_ID,
  input  logic             JumpReg_ID,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             BrTaken_ID,
  input  logic [4:0]       Rw_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rw_MEM,
  input  logic             MemRead_MEM,
  output logic             Stall_IF_ID,
  output logic             Bubble_ID_EX,
  output logic             Flush_IF_ID,
  output logic             BrResolve,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] BrCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  state_t     state;
  logic [1:0] cnt;
  logic [1:0] depth;
  logic       is_br;

  assign is_br = Branch_ID | JumpReg_ID;

  hazard_depth_calc u_depth (
    .rs          (rs),
    .rt          (rt),
    .use_rt      (Branch_ID),
    .Rw_EX       (Rw_EX),
    .RegWrite_EX (RegWrite_EX),
    .MemRead_EX  (MemRead_EX),
    .Rw_MEM      (Rw_MEM),
    .MemRead_MEM (MemRead_MEM),
    .depth       (depth)
  );

  // Outputs are forced low while reset is asserted so a mid-stall reset is visible at once.
  always_comb begin
    Stall_IF_ID  = 1'b0;
    Bubble_ID_EX = 1'b0;
    Flush_IF_ID  = 1'b0;
    BrResolve    = 1'b0;
    if (reset && !Hold) begin
      if (state == STALL) begin
        Stall_IF_ID  = 1'b1;
        Bubble_ID_EX = 1'b1;
      end else if (is_br) begin
        if (depth == STALL_NONE) begin
          BrResolve   = 1'b1;
          Flush_IF_ID = JumpReg_ID | BrTaken_ID;
        end else begin
          Stall_IF_ID  = 1'b1;
          Bubble_ID_EX = 1'b1;
        end
      end
    end
  end

  // In STALL, cnt holds the number of STALL cycles still to come, including the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= STALL_NONE;
    end else if (!Hold) begin
      unique case (state)
        IDLE: begin
          if (is_br && (depth != STALL_NONE)) begin
            cnt   <= depth - STALL_ONE;
            state <= (depth == STALL_TWO) ? STALL : IDLE;
          end
        end
        STALL: begin
          if (cnt <= STALL_ONE) begin
            cnt   <= STALL_NONE;
            state <= IDLE;
          end else begin
            cnt <= cnt - STALL_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      BrCnt    <= '0;
      TakenCnt <= '0;
    end else begin
      if (Stall_IF_ID && (StallCnt != '1))
        StallCnt <= StallCnt + CNT_W'(1);
      if (BrResolve && (BrCnt != '1))
        BrCnt <= BrCnt + CNT_W'(1);
      if (BrResolve && Flush_IF_ID && (TakenCnt != '1))
        TakenCnt <= TakenCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: single-cycle vector table plus hand-written
// multi-cycle sequences for load-use, hold, mid-stall reset and counter saturation.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       Hold, Branch_ID, JumpReg_ID, BrTaken_ID;
  logic [4:0] rs, rt, Rw_EX, Rw_MEM;
  logic       RegWrite_EX, MemRead_EX, MemRead_MEM;

  logic        Stall_IF_ID, Bubble_ID_EX, Flush_IF_ID, BrResolve;
  logic [15:0] StallCnt, BrCnt, TakenCnt;
  logic        s2_stall, s2_bubble, s2_flush, s2_resolve;
  logic [1:0]  s2_stall_cnt, s2_br_cnt, s2_taken_cnt;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk(clk), .reset(reset), .Hold(Hold), .Branch_ID(Branch_ID), .JumpReg_ID(JumpReg_ID),
    .rs(rs), .rt(rt), .BrTaken_ID(BrTaken_ID), .Rw_EX(Rw_EX), .RegWrite_EX(RegWrite_EX),
    .MemRead_EX(MemRead_EX), .Rw_MEM(Rw_MEM), .MemRead_MEM(MemRead_MEM),
    .Stall_IF_ID(Stall_IF_ID), .Bubble_ID_EX(Bubble_ID_EX), .Flush_IF_ID(Flush_IF_ID),
    .BrResolve(BrResolve), .StallCnt(StallCnt), .BrCnt(BrCnt), .TakenCnt(TakenCnt)
  );

  branch_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Hold(Hold), .Branch_ID(Branch_ID), .JumpReg_ID(JumpReg_ID),
    .rs(rs), .rt(rt), .BrTaken_ID(BrTaken_ID), .Rw_EX(Rw_EX), .RegWrite_EX(RegWrite_EX),
    .MemRead_EX(MemRead_EX), .Rw_MEM(Rw_MEM), .MemRead_MEM(MemRead_MEM),
    .Stall_IF_ID(s2_stall), .Bubble_ID_EX(s2_bubble), .Flush_IF_ID(s2_flush),
    .BrResolve(s2_resolve), .StallCnt(s2_stall_cnt), .BrCnt(s2_br_cnt), .TakenCnt(s2_taken_cnt)
  );

  typedef struct {
    string      name;
    logic       hold, br, jr;
    logic [4:0] rs, rt;
    logic       taken;
    logic [4:0] rw_ex;
    logic       we_ex, mr_ex;
    logic [4:0] rw_mem;
    logic       mr_mem;
    logic       e_stall, e_flush, e_res;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0, exp_br = 0, exp_taken = 0;
  vec_t tbl[12];

  function automatic vec_t mk(input string name, input int hold, input int br, input int jr,
                              input int rs_v, input int rt_v, input int taken,
                              input int rw_ex, input int we_ex, input int mr_ex,
                              input int rw_mem, input int mr_mem,
                              input int e_stall, input int e_flush, input int e_res);
    vec_t v;
    v.name = name;     v.hold = 1'(hold);   v.br = 1'(br);       v.jr = 1'(jr);
    v.rs = 5'(rs_v);   v.rt = 5'(rt_v);     v.taken = 1'(taken);
    v.rw_ex = 5'(rw_ex); v.we_ex = 1'(we_ex); v.mr_ex = 1'(mr_ex);
    v.rw_mem = 5'(rw_mem); v.mr_mem = 1'(mr_mem);
    v.e_stall = 1'(e_stall); v.e_flush = 1'(e_flush); v.e_res = 1'(e_res);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    Hold = v.hold;   Branch_ID = v.br;  JumpReg_ID = v.jr;
    rs = v.rs;       rt = v.rt;         BrTaken_ID = v.taken;
    Rw_EX = v.rw_ex; RegWrite_EX = v.we_ex; MemRead_EX = v.mr_ex;
    Rw_MEM = v.rw_mem; MemRead_MEM = v.mr_mem;
  endtask

  task automatic checkOutput(input vec_t v);
    check({v.name, " Stall"},    32'(Stall_IF_ID),  32'(v.e_stall));
    check({v.name, " Bubble"},   32'(Bubble_ID_EX), 32'(v.e_stall));
    check({v.name, " Flush"},    32'(Flush_IF_ID),  32'(v.e_flush));
    check({v.name, " Resolve"},  32'(BrResolve),    32'(v.e_res));
    check({v.name, " StallCnt"}, 32'(StallCnt),     32'(exp_stall));
    check({v.name, " BrCnt"},    32'(BrCnt),        32'(exp_br));
    check({v.name, " TakenCnt"}, 32'(TakenCnt),     32'(exp_taken));
    if (v.e_stall) exp_stall++;
    if (v.e_res) exp_br++;
    if (v.e_res && v.e_flush) exp_taken++;
  endtask

  task automatic run_vec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    check("reset Stall",    32'(Stall_IF_ID), 32'd0);
    check("reset Resolve",  32'(BrResolve),   32'd0);
    check("reset StallCnt", 32'(StallCnt),    32'd0);
    check("reset BrCnt",    32'(BrCnt),       32'd0);
    check("reset TakenCnt", 32'(TakenCnt),    32'd0);
    exp_stall = 0; exp_br = 0; exp_taken = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name, hold, br, jr, rs, rt, taken, rw_ex, we_ex, mr_ex, rw_mem, mr_mem, stall, flush, res
    tbl[0]  = mk("nonbranch",     0, 0, 0, 5, 6, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk("beq_not_taken", 0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk("beq_taken",     0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[3]  = mk("jr_plain",      0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk("beq_rt_ex_alu", 0, 1, 0, 1, 9, 0, 9, 1, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk("jr_ignores_rt", 0, 0, 1, 1, 9, 0, 9, 1, 0, 0, 0, 0, 1, 1);
    tbl[6]  = mk("beq_mem_load",  0, 1, 0, 6, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    tbl[7]  = mk("beq_mem_alu",   0, 1, 0, 6, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
    tbl[8]  = mk("beq_zero_reg",  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    tbl[9]  = mk("beq_ex_nowr",   0, 1, 0, 8, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk("hold_hazard",   1, 1, 0, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk("hold_jr",       1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Load in EX feeding beq: two stall cycles, producer moves to MEM meanwhile.
    do_reset();
    run_vec(mk("lw_ex_c0", 0, 1, 0, 5, 6, 0, 5, 1, 1, 0, 0, 1, 0, 0));
    run_vec(mk("lw_ex_c1", 0, 1, 0, 5, 6, 0, 0, 0, 0, 5, 1, 1, 0, 0));
    run_vec(mk("lw_ex_c2", 0, 1, 0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // ALU producer on rt, branch taken at resolve.
    run_vec(mk("add_rt_c0", 0, 1, 0, 1, 7, 0, 7, 1, 0, 0, 0, 1, 0, 0));
    run_vec(mk("add_rt_c1", 0, 1, 0, 1, 7, 1, 0, 0, 0, 7, 0, 0, 1, 1));

    // jr on $0 never waits for a $0 producer.
    run_vec(mk("jr_zero", 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));

    // Hold before the first stall and again in the middle of STALL.
    do_reset();
    run_vec(mk("hold_c0", 1, 1, 0, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0));
    run_vec(mk("hold_c1", 1, 1, 0, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0));
    run_vec(mk("hold_c2", 0, 1, 0, 3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0));
    run_vec(mk("hold_c3", 1, 1, 0, 3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    run_vec(mk("hold_c4", 0, 1, 0, 3, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0));
    run_vec(mk("hold_c5", 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset asserted while in STALL, released with the branch still in ID.
    do_reset();
    run_vec(mk("rst_c0", 0, 1, 0, 5, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0));
    applyStimulus(mk("rst_mid", 0, 1, 0, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0));
    reset = 1'b0;
    #1;
    check("rst_mid Stall",    32'(Stall_IF_ID),  32'd0);
    check("rst_mid Bubble",   32'(Bubble_ID_EX), 32'd0);
    check("rst_mid Resolve",  32'(BrResolve),    32'd0);
    check("rst_mid StallCnt", 32'(StallCnt),     32'd0);
    exp_stall = 0; exp_br = 0; exp_taken = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    run_vec(mk("rst_release", 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Five stalled branches: the 2-bit instance must stick at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_vec(mk("sat_stall", 0, 1, 0, 2, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0));
      run_vec(mk("sat_res",   0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      check("sat StallCnt2", 32'(s2_stall_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    check("sat BrCnt2",    32'(s2_br_cnt),    32'd3);
    check("sat StallCnt16", 32'(StallCnt),    32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
